// File: rtl/multiword_add_arbiter_pkg.sv
// Shared types and constants for the nibble-serial add arbiter.
// One 4-bit slice is reused across all nibbles of an operand.
package multiword_add_arbiter_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/multiword_add_arbiter_add_slice.sv
// Combinational 4-bit ripple-carry adder built from per-bit full adders.
// Each carry lives in its own generate scope so there is no self-feeding vector.
module add_slice
    import multiword_add_arbiter_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Cin,
    output logic [NIB_W-1:0] Sum,
    output logic             Cout
);

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = Cin;
        end else begin : g_chain
            assign ci = g_fa[i-1].co;
        end
        assign Sum[i] = A[i] ^ B[i] ^ ci;
        assign co     = (A[i] & B[i]) | (ci & (A[i] ^ B[i]));
    end

    assign Cout = g_fa[NIB_W-1].co;

endmodule

// File: rtl/multiword_add_arbiter.sv
// Two-requester arbiter feeding one shared nibble adder; wide sums are built
// LSB nibble first over WORDS cycles and returned on a valid/ready channel.
module multiword_add_arbiter
    import multiword_add_arbiter_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [NIB_W*WORDS-1:0] req0_a,
    input  logic [NIB_W*WORDS-1:0] req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [NIB_W*WORDS-1:0] req1_a,
    input  logic [NIB_W*WORDS-1:0] req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NIB_W*WORDS-1:0] rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_id
);

    localparam int W  = NIB_W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_t     state_q, state_d;
    req_id_t    prio_q, prio_d;
    req_id_t    id_q, id_d;
    logic [KW-1:0] k_q, k_d;
    logic       carry_q, carry_d;
    logic       cout_q, cout_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] sum_q, sum_d;

    logic       gnt1;
    logic       accept;
    logic [NIB_W-1:0] slice_s;
    logic       slice_c;

    // Operands shift right each ADD cycle so the slice always sees the low nibble.
    add_slice u_add_slice (
        .A    (a_q[NIB_W-1:0]),
        .B    (b_q[NIB_W-1:0]),
        .Cin  (carry_q),
        .Sum  (slice_s),
        .Cout (slice_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ADD;
            ADD:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requester 1 wins only when alone or when it holds priority.
    always_comb begin
        gnt1       = req1_valid & (~req0_valid | prio_q);
        req1_ready = (state_q == IDLE) & ~rst & gnt1;
        req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~gnt1;
        accept     = req0_ready | req1_ready;
        rsp_valid  = (state_q == DONE);
        rsp_sum    = sum_q;
        rsp_cout   = cout_q;
        rsp_id     = id_q;
    end

    always_comb begin
        prio_d  = prio_q;
        id_d    = id_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        if (accept) begin
            id_d    = req1_ready;
            prio_d  = ~req1_ready;
            a_d     = req1_ready ? req1_a : req0_a;
            b_d     = req1_ready ? req1_b : req0_b;
            carry_d = req1_ready ? req1_cin : req0_cin;
            k_d     = '0;
        end else if (state_q == ADD) begin
            a_d     = a_q >> NIB_W;
            b_d     = b_q >> NIB_W;
            sum_d[NIB_W*int'(k_q) +: NIB_W] = slice_s;
            carry_d = slice_c;
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) cout_d = slice_c;
        end
    end

endmodule

// File: tb/tb_multiword_add_arbiter.sv
// Scoreboard bench for multiword_add_arbiter: handshakes push a reference
// result {id, a+b+cin}; a negedge monitor pops and compares responses.
module tb_multiword_add_arbiter;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [W-1:0] rsp_sum;

    multiword_add_arbiter #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           errors = 0;
    logic         model_prio = 1'b0;
    bit           b2b = 0;
    bit           lat_pending = 0;
    int           hs_cyc = 0;
    bit           held_v = 0;
    logic [W+1:0] held;
    bit           after_rsp = 0;
    bit           running = 0;
    logic         acc_id;
    logic [W+1:0] act;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Reference: the full-width sum with carry-out, tagged by requester.
    function automatic logic [W+1:0] model(input logic id, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        return {id, s};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
            held_v      = 0;
            lat_pending = 0;
            after_rsp   = 0;
        end else begin
            if (after_rsp) check("no_bypass_after_rsp", rsp_valid, 1'b0);
            after_rsp = 0;
            if (req0_ready | req1_ready) begin
                check("ready_onehot", req0_ready & req1_ready, 1'b0);
                check("ready_wo_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 1'b0);
                acc_id = req1_ready;
                if (req0_valid && req1_valid) check("grant", acc_id, model_prio);
                model_prio = ~acc_id;
                if (acc_id) exp_q.push_back(model(1'b1, req1_a, req1_b, req1_cin));
                else        exp_q.push_back(model(1'b0, req0_a, req0_b, req0_cin));
                hs_cyc      = cyc;
                lat_pending = 1;
                if (b2b) acc_q.push_back(cyc);
            end
            act = {rsp_id, rsp_cout, rsp_sum};
            if (rsp_valid) begin
                check("ready_in_done", req0_ready | req1_ready, 1'b0);
                if (lat_pending) check("latency", cyc - hs_cyc, WORDS + 1);
                lat_pending = 0;
                if (held_v) check("hold_stable", act, held);
                if (rsp_ready) begin
                    if (exp_q.size() == 0) check("unexpected_rsp", 1'b1, 1'b0);
                    else check("result", act, exp_q.pop_front());
                    held_v    = 0;
                    after_rsp = 1;
                end else begin
                    held   = act;
                    held_v = 1;
                end
            end else if (held_v) begin
                check("hold_valid_dropped", 1'b0, 1'b1);
                held_v = 0;
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
        end
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic wait_accept(input int id);
        int t = 0;
        logic r;
        do begin
            @(negedge clk);
            r = (id == 0) ? req0_ready : req1_ready;
            t++;
        end while (!r && t < 300);
        if (!r) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        set_req(id, 1'b1, a, b, cin);
        wait_accept(id);
        set_req(id, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drive_stream(input int id, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                set_req(id, 1'b0, '0, '0, 1'b0);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            set_req(id, 1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_accept(id);
        end
        set_req(id, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        set_req(1, 1'b1, 16'h3333, 16'h4444, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        #1;
        check("reset_outputs", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, '0);

        issue(0, 16'h1234, 16'h0FFF, 1'b0);
        drain();
        issue(0, 16'hFFFF, 16'h0000, 1'b1);
        drain();
        issue(1, 16'h8000, 16'h8000, 1'b0);
        drain();

        // Both requesters continuously valid: expect alternation, 6-cycle spacing.
        b2b = 1;
        acc_q.delete();
        fork
            drive_stream(0, 2, 0);
            drive_stream(1, 2, 0);
        join
        drain();
        b2b = 0;
        check("b2b_accepts", acc_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++)
            check("b2b_spacing", acc_q[i] - acc_q[i-1], WORDS + 2);

        // Back-pressure in DONE.
        rsp_ready = 1'b0;
        issue(0, W'($urandom), W'($urandom), 1'b1);
        begin
            int t = 0;
            while (!rsp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("done_reached", rsp_valid, 1'b1);
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("release_on_ready", exp_q.size(), 0);
        drain();

        // Reset in ADD with k = 2; the operation must vanish.
        issue(0, W'($urandom), W'($urandom), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        model_prio = 1'b0;
        set_req(0, 1'b1, W'($urandom), W'($urandom), 1'b1);
        set_req(1, 1'b1, W'($urandom), W'($urandom), 1'b0);
        #1;
        check("mid_add_reset_outputs", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, '0);
        fork
            begin wait_accept(0); set_req(0, 1'b0, '0, '0, 1'b0); end
            begin wait_accept(1); set_req(1, 1'b0, '0, '0, 1'b0); end
        join
        drain();

        // Random traffic with random back-pressure.
        for (int r = 0; r < 4; r++) begin
            running = 1;
            fork
                begin
                    fork
                        drive_stream(0, $urandom_range(3, 6), 1);
                        drive_stream(1, $urandom_range(3, 6), 1);
                    join
                    running = 0;
                end
                begin
                    while (running) begin
                        @(posedge clk); #1;
                        rsp_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            rsp_ready = 1'b1;
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
